sram_controller: RTL

//   Synchronous host-side initiator for the asynchronous 256K x 8 SRAM (bCE/bWE active-low).

---
 rtl/sram_controller.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sram_controller.sv
// Host-side initiator for a 256K x 8 asynchronous SRAM; Done rises WaitStates+2 edges after an accepted Req.
// No request queue: Req is taken only while Ready is high; otherwise the host must hold or re-issue it.
module sram_controller #(
    parameter int AddressSize = 18,
    parameter int WordSize    = 8,
    parameter int WaitStates  = 2,
    parameter int TurnCycles  = 1
) (
    input  logic                   Clock,
    input  logic                   bReset,
    input  logic                   Req,
    input  logic                   RdWr,
    input  logic [AddressSize-1:0] HostAddr,
    input  logic [WordSize-1:0]    HostWData,
    output logic                   Ready,
    output logic                   Done,
    output logic [WordSize-1:0]    RdData,
    output logic [AddressSize-1:0] Address,
    output logic [WordSize-1:0]    InData,
    input  logic [WordSize-1:0]    OutData,
    output logic                   bCE,
    output logic                   bWE
);

    localparam int CountW = (WaitStates > 1) ? $clog2(WaitStates + 1) : 1;
    localparam int TurnW  = (TurnCycles > 1) ? $clog2(TurnCycles + 1) : 1;
    localparam logic [CountW-1:0] WaitLoad = CountW'(WaitStates - 1);
    localparam logic [TurnW-1:0]  TurnLoad = (TurnCycles > 0) ? TurnW'(TurnCycles - 1) : '0;

    typedef enum logic [2:0] {
        Idle,
        Setup,
        Access,
        Hold,
        Recover
    } stateT;

    stateT                   state;
    stateT                   stateNext;
    logic [CountW-1:0]       waitCount;
    logic [CountW-1:0]       waitCountNext;
    logic [TurnW-1:0]        turnCount;
    logic [TurnW-1:0]        turnCountNext;
    logic                    isWrite;
    logic                    isWriteNext;
    logic                    bCENext;
    logic                    bWENext;
    logic                    doneNext;
    logic [AddressSize-1:0]  addressNext;
    logic [WordSize-1:0]     inDataNext;
    logic [WordSize-1:0]     rdDataNext;

    assign Ready = (state == Idle) & bReset;

    always_ff @(posedge Clock) begin
        if (!bReset) begin
            state     <= Idle;
            waitCount <= '0;
            turnCount <= '0;
            isWrite   <= 1'b0;
            bCE       <= 1'b1;
            bWE       <= 1'b1;
            Done      <= 1'b0;
            Address   <= '0;
            InData    <= '0;
            RdData    <= '0;
        end else begin
            state     <= stateNext;
            waitCount <= waitCountNext;
            turnCount <= turnCountNext;
            isWrite   <= isWriteNext;
            bCE       <= bCENext;
            bWE       <= bWENext;
            Done      <= doneNext;
            Address   <= addressNext;
            InData    <= inDataNext;
            RdData    <= rdDataNext;
        end
    end

    // Address/InData only move in Idle, where bCE is high, so the SRAM never sees them change mid-access.
    always_comb begin
        stateNext     = state;
        waitCountNext = waitCount;
        turnCountNext = turnCount;
        isWriteNext   = isWrite;
        bCENext       = bCE;
        bWENext       = 1'b1;
        doneNext      = 1'b0;
        addressNext   = Address;
        inDataNext    = InData;
        rdDataNext    = RdData;
        case (state)
            Idle: begin
                bCENext = 1'b1;
                if (Req) begin
                    addressNext = HostAddr;
                    inDataNext  = HostWData;
                    isWriteNext = RdWr;
                    bCENext     = 1'b0;
                    stateNext   = Setup;
                end
            end
            Setup: begin
                bWENext       = !isWrite;
                waitCountNext = WaitLoad;
                stateNext     = Access;
            end
            Access: begin
                if (waitCount == '0) begin
                    stateNext = Hold;
                end else begin
                    bWENext       = !isWrite;
                    waitCountNext = waitCount - 1'b1;
                end
            end
            Hold: begin
                // bCE is still low here, so OutData is driven by the SRAM, never Z.
                if (!isWrite) begin
                    rdDataNext = OutData;
                end
                bCENext  = 1'b1;
                doneNext = 1'b1;
                if (TurnCycles > 0) begin
                    turnCountNext = TurnLoad;
                    stateNext     = Recover;
                end else begin
                    stateNext = Idle;
                end
            end
            Recover: begin
                bCENext = 1'b1;
                if (turnCount == '0) begin
                    stateNext = Idle;
                end else begin
                    turnCountNext = turnCount - 1'b1;
                end
            end
            default: begin
                bCENext   = 1'b1;
                stateNext = Idle;
            end
        endcase
    end

endmodule
